alu_iterative: RTL and testbench

Multi-cycle ALU that executes the 4-bit `Operation` code produced by the ALU controller on two 32-bit operands. It sits in the execute stage of the multi-cycle datapath. Logic, arithmetic and compare operations complete in one cycle; shifts are performed iteratively, one bit position per cycle. The block uses a valid/ready handshake on both the operand side and the result side, so the surrounding control FSM can stall on it.

---
 rtl/alu_iterative.sv | 131 +++++++++++++
 tb/tb_alu_iterative.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: logic/arith/compare ops finish in one cycle, shifts run one bit per cycle.
// Valid/ready handshake on both the operand and the result side.
module alu_iterative #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int SHAMT_WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = 4'b0101;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = 4'b0111;
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = 4'b1100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]    work;
  logic [SHAMT_WIDTH-1:0]   cnt;

  logic [DATA_WIDTH-1:0]    comb_res;
  logic [DATA_WIDTH-1:0]    shift_next;
  logic [SHAMT_WIDTH-1:0]   shamt;
  logic                     is_shift;
  logic                     accept;

  assign shamt  = SrcB[SHAMT_WIDTH-1:0];
  assign accept = in_valid && in_ready;

  always_comb begin
    comb_res = '0;
    is_shift = 1'b0;
    case (Operation)
      OP_AND: comb_res = SrcA & SrcB;
      OP_OR:  comb_res = SrcA | SrcB;
      OP_ADD: comb_res = SrcA + SrcB;
      OP_SUB: comb_res = SrcA - SrcB;
      OP_XOR: comb_res = SrcA ^ SrcB;
      OP_SLT: comb_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      OP_EQ:  comb_res = DATA_WIDTH'(SrcA == SrcB);
      OP_SLL, OP_SRL, OP_SRA: begin
        comb_res = SrcA;
        is_shift = 1'b1;
      end
      default: comb_res = '0;
    endcase
  end

  always_comb begin
    shift_next = '0;
    case (op_q)
      OP_SLL:  shift_next = {work[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, work[DATA_WIDTH-1:1]};
      default: shift_next = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      op_q      <= '0;
      work      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            // Zero shift amount short-circuits straight to DONE with SrcA as result.
            if (is_shift && shamt != '0) begin
              op_q  <= Operation;
              work  <= SrcA;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              ALUResult <= comb_res;
              Zero      <= (comb_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= shift_next;
          cnt  <= cnt - 1'b1;
          if (cnt == SHAMT_WIDTH'(1)) begin
            ALUResult <= shift_next;
            Zero      <= (shift_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed-vector bench for alu_iterative; inputs driven and outputs sampled on the falling edge.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  alu_iterative #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .SHAMT_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready high, scramble operands after accept, measure latency.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input int unsigned exp_lat);
    int unsigned lat;
    logic        ready_leak;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    Operation = 4'b0010;
    SrcA      = ~a;
    SrcB      = 32'h5A5A_5A5A;
    lat        = 1;
    ready_leak = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_leak = 1'b1;
      lat++;
      @(negedge clk);
    end
    if (in_ready) ready_leak = 1'b1;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, {31'b0, ready_leak}, 32'd0);
    chk({tag, "_res"}, ALUResult, exp_res);
    chk({tag, "_zero"}, {31'b0, Zero}, {31'b0, exp_zero});
    @(negedge clk);
    chk({tag, "_handoff"}, {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    Operation = 4'b0010;
    SrcA      = 32'd1;
    SrcB      = 32'd1;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_flags", {30'b0, in_ready, out_valid}, 32'd2);
    chk("rst_res", ALUResult, 32'd0);
    chk("rst_zero", {31'b0, Zero}, 32'd1);
    chk("rst_cnt", {27'b0, dut.cnt}, 32'd0);

    run_op("add",    4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1);
    run_op("sub",    4'b0110, 32'd5,        32'd5,        32'd0,        1'b1, 1);
    run_op("addwrap",4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1);
    run_op("and",    4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1);
    run_op("or",     4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1);
    run_op("slt",    4'b1100, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
    run_op("slt_n",  4'b1100, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1);
    run_op("eq",     4'b1000, 32'h1234,     32'h1234,     32'd1,        1'b0, 1);
    run_op("bad_op", 4'b1111, 32'h1234,     32'h5678,     32'd0,        1'b1, 1);
    run_op("sll31",  4'b0100, 32'd1,        32'd31,       32'h80000000, 1'b0, 32);
    run_op("sra4",   4'b0111, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 5);
    run_op("srl4",   4'b0101, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 5);
    run_op("sra1",   4'b0111, 32'h80000001, 32'hFFFFFFE1, 32'hC0000000, 1'b0, 2);
    run_op("sll0",   4'b0100, 32'hDEADBEEF, 32'h20,       32'hDEADBEEF, 1'b0, 1);

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    Operation = 4'b0011;
    SrcA      = 32'hFF00FF00;
    SrcB      = 32'h0F0F0F0F;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    SrcA     = 32'h0;
    SrcB     = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", {30'b0, in_ready, out_valid}, 32'd1);
      chk("bp_res", ALUResult, 32'hF00FF00F);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'b0, in_ready, out_valid}, 32'd2);
    chk("bp_zero", {31'b0, Zero}, 32'd0);

    // Reset three cycles into SLL by 10 abandons the operation.
    @(negedge clk);
    Operation = 4'b0100;
    SrcA      = 32'd1;
    SrcB      = 32'd10;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_flags", {30'b0, in_ready, out_valid}, 32'd2);
    chk("mid_rst_res", ALUResult, 32'd0);
    chk("mid_rst_zero", {31'b0, Zero}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) chk("mid_rst_ghost", {31'b0, out_valid}, 32'd0);
    end
    chk("mid_rst_idle", {30'b0, in_ready, out_valid}, 32'd2);
    run_op("add_after_rst", 4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
